// File: rtl/rv32_types_pkg.sv
// Shared RV32 decode types.
//  - RV_NOP / create_nop_ctrl / create_bubble : canonical bubble contents
//  - ctrl_t               : decoded control fields handed to exec
//  - ibuf_entry_t         : one instruction-queue slot {pc, instr}
//  - bypass_t             : forwarding-source select, 0 = register file, k+1 = source k
//  - decode_exec_buffer_t : registered decode -> exec payload
package rv32_types;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // bypass_t is sized for FWD_SRCS sources; a decode stage must not scan more.
  localparam int unsigned FWD_SRCS = 2;
  localparam int unsigned BYPASS_W = $clog2(FWD_SRCS + 1);
  typedef logic [BYPASS_W-1:0] bypass_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b000_0011,
    OPC_OP_IMM = 7'b001_0011,
    OPC_AUIPC  = 7'b001_0111,
    OPC_STORE  = 7'b010_0011,
    OPC_OP     = 7'b011_0011,
    OPC_LUI    = 7'b011_0111,
    OPC_BRANCH = 7'b110_0011,
    OPC_JALR   = 7'b110_0111,
    OPC_JAL    = 7'b110_1111
  } opcode_e;

  typedef struct packed {
    logic        use_rs1;
    logic        use_rs2;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [3:0]  alu_op;   // {funct7[5], funct3}
    logic [31:0] imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    ctrl_t       ctrl;
    logic [31:0] reg1;
    logic [31:0] reg2;
    bypass_t     bypass_rs1;
    bypass_t     bypass_rs2;
  } decode_exec_buffer_t;

  function automatic ctrl_t create_nop_ctrl();
    return '0;
  endfunction

  function automatic decode_exec_buffer_t create_bubble(input logic [31:0] pc);
    decode_exec_buffer_t b;
    b       = '0;
    b.pc    = pc;
    b.instr = RV_NOP;
    b.ctrl  = create_nop_ctrl();
    return b;
  endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I instruction decoder.
//  instr_i : instruction word
//  ctrl_o  : decoded control (register uses, writeback, ALU op, immediate, mem/flow flags)
module rv32_decoder
  import rv32_types::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o    = create_nop_ctrl();
    ctrl_o.rd = instr_i[11:7];
    case (opcode_e'(instr_i[6:0]))
      OPC_OP: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.rd_wen  = 1'b1;
        ctrl_o.alu_op  = {instr_i[30], instr_i[14:12]};
      end
      OPC_OP_IMM: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.rd_wen  = 1'b1;
        ctrl_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
        // Only SRAI carries an op bit in the immediate field.
        ctrl_o.alu_op  = {(instr_i[14:12] == 3'b101) & instr_i[30], instr_i[14:12]};
      end
      OPC_LOAD: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.rd_wen  = 1'b1;
        ctrl_o.mem_rd  = 1'b1;
        ctrl_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.mem_wr  = 1'b1;
        ctrl_o.imm     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_o.rd_wen = 1'b1;
        ctrl_o.imm    = {instr_i[31:12], 12'h000};
      end
      OPC_BRANCH: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.branch  = 1'b1;
        ctrl_o.imm     = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
      end
      OPC_JAL: begin
        ctrl_o.rd_wen = 1'b1;
        ctrl_o.jump   = 1'b1;
        ctrl_o.imm    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.rd_wen  = 1'b1;
        ctrl_o.jump    = 1'b1;
        ctrl_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      default: ;
    endcase
    ctrl_o.rd_wen = ctrl_o.rd_wen & (ctrl_o.rd != 5'd0);
  end

endmodule

// File: rtl/rv32_hazard_scan.sv
// Combinational operand hazard / bypass selection over NUM_FWD later stages.
//  use_rs_i    : operand is read by the instruction ([0]=rs1, [1]=rs2)
//  rs_addr_i   : operand register addresses
//  fwd_rd_i    : destination register per stage, index 0 = youngest
//  fwd_wen_i   : stage will write fwd_rd_i
//  fwd_ready_i : stage result already available for bypass
//  bypass_o    : per-operand source select (0 = register file, k+1 = stage k)
//  hazard_o    : some operand's youngest producer is not ready yet
module rv32_hazard_scan
  import rv32_types::*;
#(
  parameter int unsigned NUM_FWD = FWD_SRCS
) (
  input  logic [1:0]              use_rs_i,
  input  logic [1:0][4:0]         rs_addr_i,
  input  logic [NUM_FWD-1:0][4:0] fwd_rd_i,
  input  logic [NUM_FWD-1:0]      fwd_wen_i,
  input  logic [NUM_FWD-1:0]      fwd_ready_i,
  output bypass_t [1:0]           bypass_o,
  output logic                    hazard_o
);

  logic [1:0] op_haz;

  // Walk oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    bypass_o = '0;
    op_haz   = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned k = NUM_FWD; k > 0; k--) begin
        if (use_rs_i[r] && (rs_addr_i[r] != 5'd0) && fwd_wen_i[k-1] &&
            (fwd_rd_i[k-1] == rs_addr_i[r])) begin
          bypass_o[r] = fwd_ready_i[k-1] ? bypass_t'(k) : '0;
          op_haz[r]   = ~fwd_ready_i[k-1];
        end
      end
    end
    hazard_o = |op_haz;
  end

endmodule

// File: rtl/rv32_buffered_decode_stage.sv
// Decode stage with an instruction queue between fetch and decode.
//  clk, resetn       : clock, synchronous active-low reset
//  flush, flush_pc   : redirect: drop queue, emit bubble carrying flush_pc
//  stop              : freeze queue, output register and stall counter
//  f_valid/f_ready   : fetch handshake for {f_pc, f_instr}
//  rs_addr, reg_data : register-file read port driven from the queue head
//  fwd_rd/wen/ready  : later-stage writers used for bypass and hazard detection
//  decode_exec_buff  : registered decode result to exec
//  stall             : head present but blocked by a not-ready producer
//  perf_stall_cnt    : wrapping count of stall cycles
module rv32_buffered_decode_stage
  import rv32_types::*;
#(
  parameter int unsigned IBUF_DEPTH = 2,
  parameter int unsigned NUM_FWD    = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [31:0]             flush_pc,
  input  logic                    stop,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic [31:0]             f_pc,
  input  logic [31:0]             f_instr,
  output logic [1:0][4:0]         rs_addr,
  input  logic [1:0][31:0]        reg_data,
  input  logic [NUM_FWD-1:0][4:0] fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_wen,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  output decode_exec_buffer_t     decode_exec_buff,
  output logic                    stall,
  output logic [31:0]             perf_stall_cnt
);

  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);

  ibuf_entry_t         ibuf_q [IBUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  decode_exec_buffer_t out_q, out_d;
  logic [31:0]         stall_cnt_q;

  logic          head_valid, hazard, push, pop;
  ibuf_entry_t   head;
  logic [31:0]   dec_instr;
  ctrl_t         dec_ctrl;
  bypass_t [1:0] bypass;

  assign head_valid = (count_q != '0);
  assign head       = ibuf_q[rd_ptr_q];
  assign dec_instr  = head_valid ? head.instr : RV_NOP;
  assign rs_addr[0] = dec_instr[19:15];
  assign rs_addr[1] = dec_instr[24:20];

  // Deliberately independent of pop: a full queue refuses even while draining.
  assign f_ready = (count_q < CNT_W'(IBUF_DEPTH)) & ~stop & ~flush & resetn;
  assign push    = f_valid & f_ready;
  assign pop     = head_valid & ~hazard & ~stop & ~flush;
  assign stall   = head_valid & hazard;

  rv32_decoder u_decoder (
    .instr_i (dec_instr),
    .ctrl_o  (dec_ctrl)
  );

  rv32_hazard_scan #(.NUM_FWD(NUM_FWD)) u_hazard_scan (
    .use_rs_i    ({dec_ctrl.use_rs2, dec_ctrl.use_rs1}),
    .rs_addr_i   (rs_addr),
    .fwd_rd_i    (fwd_rd),
    .fwd_wen_i   (fwd_wen),
    .fwd_ready_i (fwd_ready),
    .bypass_o    (bypass),
    .hazard_o    (hazard)
  );

  always_comb begin
    if (flush) begin
      out_d = create_bubble(flush_pc);
    end else if (pop) begin
      out_d            = '0;
      out_d.pc         = head.pc;
      out_d.instr      = head.instr;
      out_d.ctrl       = dec_ctrl;
      out_d.reg1       = reg_data[0];
      out_d.reg2       = reg_data[1];
      out_d.bypass_rs1 = bypass[0];
      out_d.bypass_rs2 = bypass[1];
    end else begin
      out_d = create_bubble(head_valid ? head.pc : out_q.pc);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= create_bubble('0);
      stall_cnt_q <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= out_d;
    end else if (!stop) begin
      out_q <= out_d;
      if (push) begin
        ibuf_q[wr_ptr_q] <= '{pc: f_pc, instr: f_instr};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign decode_exec_buff = out_q;
  assign perf_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_rv32_buffered_decode_stage.sv
module tb_rv32_buffered_decode_stage;
  import rv32_types::*;

  localparam int DEPTH = 2;
  localparam int NFWD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 resetn, flush, stop, f_valid, f_ready, stall;
  logic [31:0]          flush_pc, f_pc, f_instr, perf_stall_cnt;
  logic [1:0][4:0]      rs_addr;
  logic [1:0][31:0]     reg_data;
  logic [NFWD-1:0][4:0] fwd_rd;
  logic [NFWD-1:0]      fwd_wen, fwd_ready;
  decode_exec_buffer_t  decode_exec_buff;

  rv32_buffered_decode_stage #(.IBUF_DEPTH(DEPTH), .NUM_FWD(NFWD)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .flush_pc(flush_pc), .stop(stop),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_instr(f_instr),
    .rs_addr(rs_addr), .reg_data(reg_data), .fwd_rd(fwd_rd), .fwd_wen(fwd_wen),
    .fwd_ready(fwd_ready), .decode_exec_buff(decode_exec_buff), .stall(stall),
    .perf_stall_cnt(perf_stall_cnt)
  );

  // Register file behind the read port.
  logic [31:0] rf [32];
  assign reg_data[0] = rf[rs_addr[0]];
  assign reg_data[1] = rf[rs_addr[1]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    ctrl_t       ctrl;
  } m_entry_t;

  typedef struct packed {
    logic                chk_comb;
    logic                chk_seq;
    logic                fr;
    logic                st;
    logic [1:0][4:0]     rsa;
    decode_exec_buffer_t out;
    logic [31:0]         cnt;
  } exp_t;

  m_entry_t            mq [$];
  exp_t                exp_q [$];
  m_entry_t            cur_f;
  decode_exec_buffer_t m_out;
  logic [31:0]         m_cnt;
  bit                  m_init;
  int                  n_tests = 0;
  int                  n_fail  = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic decode_exec_buffer_t exp_bubble(input logic [31:0] pc);
    decode_exec_buffer_t b;
    b       = '0;
    b.pc    = pc;
    b.instr = 32'h0000_0013;
    return b;
  endfunction

  // Encode an instruction from its fields and record what decode must report for it.
  // kind: 0 ADDI, 1 ADD, 2 SUB, 3 LW, 4 SW, else LUI
  function automatic m_entry_t make_instr(input logic [31:0] pc, input int kind,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    m_entry_t e;
    e         = '0;
    e.pc      = pc;
    e.ctrl.rd = rd;
    case (kind)
      0: begin
        e.instr = {imm, rs1, 3'b000, rd, 7'h13};
        e.ctrl.use_rs1 = 1'b1; e.ctrl.rd_wen = (rd != 0);
        e.ctrl.imm = {{20{imm[11]}}, imm};
      end
      1, 2: begin
        e.instr = {(kind == 2) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
        e.ctrl.use_rs1 = 1'b1; e.ctrl.use_rs2 = 1'b1; e.ctrl.rd_wen = (rd != 0);
        e.ctrl.alu_op = (kind == 2) ? 4'd8 : 4'd0;
      end
      3: begin
        e.instr = {imm, rs1, 3'b010, rd, 7'h03};
        e.ctrl.use_rs1 = 1'b1; e.ctrl.rd_wen = (rd != 0); e.ctrl.mem_rd = 1'b1;
        e.ctrl.imm = {{20{imm[11]}}, imm};
      end
      4: begin
        e.instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
        e.ctrl.use_rs1 = 1'b1; e.ctrl.use_rs2 = 1'b1; e.ctrl.mem_wr = 1'b1;
        e.ctrl.rd = imm[4:0];
        e.ctrl.imm = {{20{imm[11]}}, imm};
      end
      default: begin
        e.instr = {imm, 8'h5A, rd, 7'h37};
        e.ctrl.rd_wen = (rd != 0);
        e.ctrl.imm = {imm, 8'h5A, 12'h000};
      end
    endcase
    return e;
  endfunction

  // Reference model: one clock of the stage, written from the behavioural rules.
  task automatic model_step();
    exp_t        r;
    bit          hv, haz, fr;
    m_entry_t    h;
    logic [4:0]  rs [2];
    bit          usev [2];
    bypass_t     sel [2];
    int          hit;
    logic [31:0] hi;
    hv  = (mq.size() > 0);
    fr  = resetn && (mq.size() < DEPTH) && !stop && !flush;
    haz = 0;
    sel[0] = '0; sel[1] = '0;
    h = hv ? mq[0] : '0;
    hi = hv ? h.instr : 32'h0000_0013;
    rs[0] = hi[19:15]; rs[1] = hi[24:20];
    usev[0] = hv && h.ctrl.use_rs1; usev[1] = hv && h.ctrl.use_rs2;
    for (int r = 0; r < 2; r++) begin
      if (usev[r] && rs[r] != 5'd0) begin
        hit = -1;
        for (int k = 0; k < NFWD; k++)
          if (hit < 0 && fwd_wen[k] && fwd_rd[k] == rs[r]) hit = k;
        if (hit >= 0) begin
          if (fwd_ready[hit]) sel[r] = bypass_t'(hit + 1);
          else haz = 1;
        end
      end
    end
    r.chk_comb = m_init;
    r.fr = fr;
    r.st = hv && haz;
    r.rsa[0] = rs[0]; r.rsa[1] = rs[1];
    if (!resetn) begin
      mq.delete();
      m_out  = exp_bubble(32'h0);
      m_cnt  = 32'h0;
      m_init = 1;
    end else if (flush) begin
      mq.delete();
      m_out = exp_bubble(flush_pc);
    end else if (!stop) begin
      if (hv && !haz) begin
        m_out            = '0;
        m_out.pc         = h.pc;
        m_out.instr      = h.instr;
        m_out.ctrl       = h.ctrl;
        m_out.reg1       = rf[rs[0]];
        m_out.reg2       = rf[rs[1]];
        m_out.bypass_rs1 = sel[0];
        m_out.bypass_rs2 = sel[1];
        void'(mq.pop_front());
      end else begin
        m_out = exp_bubble(hv ? h.pc : m_out.pc);
      end
      if (hv && haz) m_cnt = m_cnt + 32'd1;
      if (f_valid && fr) mq.push_back(cur_f);
    end
    r.chk_seq = m_init;
    r.out = m_out;
    r.cnt = m_cnt;
    exp_q.push_back(r);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.chk_comb || !resetn) check("f_ready", 192'(f_ready), 192'(r.fr));
        if (r.chk_comb) begin
          check("stall", 192'(stall), 192'(r.st));
          check("rs_addr", 192'(rs_addr), 192'(r.rsa));
        end
        @(posedge clk);
        #1;
        if (r.chk_seq) begin
          check("decode_exec_buff", 192'(decode_exec_buff), 192'(r.out));
          check("perf_stall_cnt", 192'(perf_stall_cnt), 192'(r.cnt));
        end
      end
    end
  end

  task automatic idle_inputs();
    resetn = 1'b1; flush = 1'b0; stop = 1'b0; f_valid = 1'b0;
    fwd_rd = '0; fwd_wen = '0; fwd_ready = '1;
  endtask

  task automatic offer(input m_entry_t e);
    cur_f   = e;
    f_pc    = e.pc;
    f_instr = e.instr;
    f_valid = 1'b1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_in_flight_x5();
    fwd_rd[0] = 5'd5; fwd_wen = 2'b01; fwd_ready = 2'b10;
  endtask

  initial begin
    logic [31:0] pcc;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    resetn = 1'b0; flush = 1'b0; stop = 1'b0; f_valid = 1'b0;
    flush_pc = '0; f_pc = '0; f_instr = '0; fwd_rd = '0; fwd_wen = '0; fwd_ready = '0;
    cur_f = '0; m_out = '0; m_cnt = '0; m_init = 0;
    @(posedge clk);
    #2;
    step(); step();
    idle_inputs();
    step();

    // Three back-to-back ADDIs, no hazards.
    for (int i = 0; i < 3; i++) begin
      offer(make_instr(32'(i * 4), 0, 5'(i + 1), 5'd0, 5'd0, 12'(i + 7)));
      step();
    end
    f_valid = 1'b0;
    repeat (3) step();

    // Bypass from the youngest stage, then from the oldest.
    fwd_rd[0] = 5'd1; fwd_wen = 2'b01; fwd_ready = 2'b11;
    offer(make_instr(32'h20, 1, 5'd3, 5'd1, 5'd2, 12'h0));
    step(); f_valid = 1'b0; step(); step();
    fwd_rd[1] = 5'd2; fwd_wen = 2'b11;
    offer(make_instr(32'h24, 1, 5'd3, 5'd1, 5'd2, 12'h0));
    step(); f_valid = 1'b0; step(); step();

    // Load-use: two stall cycles, then bypass from the older stage.
    idle_inputs();
    load_in_flight_x5();
    offer(make_instr(32'h30, 1, 5'd6, 5'd5, 5'd0, 12'h0));
    step(); f_valid = 1'b0; step(); step();
    fwd_wen = 2'b10; fwd_rd[1] = 5'd5; fwd_ready = 2'b11;
    step(); step();

    // Fill while stalled, then release and watch f_ready recover.
    idle_inputs();
    load_in_flight_x5();
    for (int i = 0; i < 4; i++) begin
      offer(make_instr(32'h40 + 32'(i * 4), 2, 5'd7, 5'd5, 5'd1, 12'h0));
      step();
    end
    fwd_wen = '0;
    for (int i = 4; i < 7; i++) begin
      offer(make_instr(32'h40 + 32'(i * 4), 0, 5'd8, 5'd2, 5'd0, 12'hFFF));
      step();
    end
    f_valid = 1'b0;
    repeat (3) step();

    // Flush overrides stop on a full queue.
    load_in_flight_x5();
    offer(make_instr(32'h60, 1, 5'd9, 5'd5, 5'd0, 12'h0)); step();
    offer(make_instr(32'h64, 3, 5'd9, 5'd5, 5'd0, 12'h80)); step();
    stop = 1'b1; flush = 1'b1; flush_pc = 32'h100; step();
    idle_inputs();
    step(); step();

    // Reset mid-stream with two entries queued.
    load_in_flight_x5();
    offer(make_instr(32'h70, 4, 5'd0, 5'd5, 5'd3, 12'h9C)); step();
    offer(make_instr(32'h74, 5, 5'd4, 5'd0, 5'd0, 12'hABC)); step();
    resetn = 1'b0; step();
    idle_inputs();
    step(); step();

    // Randomized traffic.
    pcc = 32'h1000;
    for (int c = 0; c < 1500; c++) begin
      resetn   = ($urandom_range(0, 99) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      flush_pc = {$urandom_range(0, 1023), 2'b00};
      for (int k = 0; k < NFWD; k++) begin
        fwd_rd[k]    = 5'($urandom_range(0, 7));
        fwd_wen[k]   = 1'($urandom_range(0, 1));
        fwd_ready[k] = ($urandom_range(0, 3) != 0);
      end
      offer(make_instr(pcc, int'($urandom_range(0, 5)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom)));
      f_valid = ($urandom_range(0, 3) != 0);
      pcc = pcc + 32'd4;
      step();
    end

    idle_inputs();
    repeat (3) step();
    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
